// File: rtl/conv_sched.sv
// Raster-order window sequencer for the 3x3 conv kernel: fetches 9 zero-padded taps per pixel,
// issues the window, and writes the returned ReLU result into the bank chosen by sel.
module conv_sched #(
  parameter int W_BITS = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_rd,
  output logic [2*W_BITS-1:0]   mem_addr,
  input  logic [19:0]           mem_rdata,
  output logic                  k_valid,
  output logic [179:0]          k_data,
  output logic                  k_sel,
  input  logic                  k_o_valid,
  input  logic [18:0]           k_o_data,
  output logic                  wr_en,
  output logic                  wr_sel,
  output logic [2*W_BITS-1:0]   wr_addr,
  output logic [19:0]           wr_data
);

  localparam int AW = 2 * W_BITS;

  typedef enum logic [2:0] {IDLE, FETCH, LAST, DRAIN, DONE} state_t;

  state_t              state;
  logic [3:0]          tap;
  logic [W_BITS-1:0]   row, col, nrow, ncol;
  logic                sel, nsel, last_win;
  logic [8:0][19:0]    win, win_cap;
  logic [3:0]          cap_idx;
  logic                cap_pad;
  logic                pending, pend_sel;
  logic [AW-1:0]       pend_addr;

  // Returns {in_bounds, row, col} for tap t of the window centred on (r, c).
  // Coordinates are offset by +1 so the bounds test stays unsigned: valid range is 1..N.
  function automatic logic [AW:0] tap_fetch(input logic [W_BITS-1:0] r,
                                            input logic [W_BITS-1:0] c,
                                            input logic [3:0] t);
    logic [W_BITS+1:0] rr, cc, rm, cm;
    logic [3:0]        dyi, dxi;
    logic              inb;
    dyi = t / 4'd3;
    dxi = t % 4'd3;
    rr  = {2'b00, r} + (W_BITS+2)'(dyi);
    cc  = {2'b00, c} + (W_BITS+2)'(dxi);
    inb = (rr != '0) && (rr <= (W_BITS+2)'(1 << W_BITS)) &&
          (cc != '0) && (cc <= (W_BITS+2)'(1 << W_BITS));
    rm  = rr - (W_BITS+2)'(1);
    cm  = cc - (W_BITS+2)'(1);
    if (inb) return {1'b1, rm[W_BITS-1:0], cm[W_BITS-1:0]};
    else     return '0;
  endfunction

  always_comb begin
    last_win = (&col) & (&row) & sel;
    ncol     = col + W_BITS'(1);
    nrow     = (&col) ? row + W_BITS'(1) : row;
    nsel     = ((&col) & (&row)) ? 1'b1 : sel;
    // mem_rdata this cycle belongs to the previous tap; LAST carries tap 8.
    cap_idx  = (state == LAST) ? 4'd8 : tap - 4'd1;
    win_cap  = win;
    for (int s = 0; s < 9; s++) begin
      if (cap_idx == 4'(s)) win_cap[s] = cap_pad ? 20'd0 : mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      tap       <= '0;
      row       <= '0;
      col       <= '0;
      sel       <= 1'b0;
      win       <= '0;
      cap_pad   <= 1'b0;
      pending   <= 1'b0;
      pend_sel  <= 1'b0;
      pend_addr <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_rd    <= 1'b0;
      mem_addr  <= '0;
      k_valid   <= 1'b0;
      k_data    <= '0;
      k_sel     <= 1'b0;
      wr_en     <= 1'b0;
      wr_sel    <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      done     <= 1'b0;
      k_valid  <= 1'b0;
      k_sel    <= 1'b0;
      wr_en    <= 1'b0;
      wr_sel   <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      mem_rd   <= 1'b0;
      mem_addr <= '0;
      cap_pad  <= ~mem_rd;

      if (k_o_valid && pending) begin
        wr_en   <= 1'b1;
        wr_sel  <= pend_sel;
        wr_addr <= pend_addr;
        wr_data <= {1'b0, k_o_data};
        pending <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start) begin
            row   <= '0;
            col   <= '0;
            sel   <= 1'b0;
            tap   <= '0;
            busy  <= 1'b1;
            state <= FETCH;
            {mem_rd, mem_addr} <= tap_fetch('0, '0, 4'd0);
          end
        end
        FETCH: begin
          win <= win_cap;
          if (tap == 4'd8) begin
            state <= LAST;
          end else begin
            tap <= tap + 4'd1;
            {mem_rd, mem_addr} <= tap_fetch(row, col, tap + 4'd1);
          end
        end
        LAST: begin
          win       <= win_cap;
          k_data    <= win_cap;
          k_valid   <= 1'b1;
          k_sel     <= sel;
          pending   <= 1'b1;
          pend_sel  <= sel;
          pend_addr <= {row, col};
          if (last_win) begin
            state <= DRAIN;
          end else begin
            row   <= nrow;
            col   <= ncol;
            sel   <= nsel;
            tap   <= '0;
            state <= FETCH;
            {mem_rd, mem_addr} <= tap_fetch(nrow, ncol, 4'd0);
          end
        end
        DRAIN: begin
          if (wr_en) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_sched.sv
// Directed bench for conv_sched at W_BITS=2 with a synchronous image RAM (pixel = address)
// and a latency-3 kernel stand-in (sel0: 3x3 sum, sel1: Laplacian, both ReLU).
module tb_conv_sched;

  localparam int WB = 2;
  localparam int N  = 1 << WB;
  localparam int AW = 2 * WB;

  logic            clk = 1'b0;
  logic            reset, start;
  logic            busy, done, mem_rd, k_valid, k_sel, k_o_valid, wr_en, wr_sel;
  logic [AW-1:0]   mem_addr, wr_addr;
  logic [19:0]     mem_rdata, wr_data;
  logic [179:0]    k_data;
  logic [18:0]     k_o_data;

  logic            rnd_on, rnd_kv, spur, mark;
  logic [18:0]     rnd_kd;
  logic [19:0]     rnd_md, mem_q;
  logic            kv1, kv2, kv3;
  logic [18:0]     kd1, kd2, kd3;

  int cyc = 1000;
  int n_checks = 0;
  int n_errors = 0;
  int kv_n, wr_n, rd_cnt;

  always #5 clk = ~clk;

  conv_sched #(.W_BITS(WB)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .k_valid(k_valid), .k_data(k_data), .k_sel(k_sel),
    .k_o_valid(k_o_valid), .k_o_data(k_o_data),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  task automatic check(input string tag, input logic [179:0] got, input logic [179:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int pix(input int r, input int c);
    if (r < 0 || r >= N || c < 0 || c >= N) return 0;
    return r * N + c;
  endfunction

  function automatic logic [179:0] exp_win(input int r, input int c);
    logic [179:0] d;
    d = '0;
    for (int s = 0; s < 9; s++) d[s*20 +: 20] = 20'(pix(r + s / 3 - 1, c + s % 3 - 1));
    return d;
  endfunction

  function automatic logic [18:0] kern(input logic [179:0] d, input logic s);
    int v[9];
    int acc;
    for (int i = 0; i < 9; i++) v[i] = int'(d[i*20 +: 20]);
    acc = 0;
    if (s) acc = 4 * v[4] - v[1] - v[3] - v[5] - v[7];
    else for (int i = 0; i < 9; i++) acc += v[i];
    if (acc < 0) acc = 0;
    return 19'(acc);
  endfunction

  function automatic logic [18:0] gold(input int r, input int c, input int s);
    int acc;
    acc = 0;
    if (s != 0) acc = 4 * pix(r, c) - pix(r - 1, c) - pix(r, c - 1) - pix(r, c + 1) - pix(r + 1, c);
    else for (int dy = -1; dy <= 1; dy++) for (int dx = -1; dx <= 1; dx++) acc += pix(r + dy, c + dx);
    if (acc < 0) acc = 0;
    return 19'(acc);
  endfunction

  function automatic logic [19:0] slot(input logic [179:0] d, input int s);
    return d[s*20 +: 20];
  endfunction

  // Image RAM: returns a garbage pattern when not read so padding must come from the DUT.
  always @(posedge clk) mem_q <= mem_rd ? {16'd0, mem_addr} : 20'hFFFFF;

  always @(posedge clk) begin
    kv1 <= k_valid; kd1 <= kern(k_data, k_sel);
    kv2 <= kv1;     kd2 <= kd1;
    kv3 <= kv2;     kd3 <= kd2;
  end

  assign mem_rdata = rnd_on ? rnd_md : mem_q;
  assign k_o_valid = rnd_on ? rnd_kv : (kv3 | spur);
  assign k_o_data  = rnd_on ? rnd_kd : kd3;

  always @(posedge clk) cyc <= mark ? 1 : cyc + 1;

  always @(negedge clk) begin
    int w;
    if (cyc == 1) begin kv_n = 0; wr_n = 0; rd_cnt = 0; end
    if (cyc >= 1 && cyc <= 9 && mem_rd) rd_cnt++;
    if (cyc == 10) check("rd_taps_w0", 180'(rd_cnt), 180'(4));
    if (k_valid) begin
      w = kv_n;
      check("kv_cyc", 180'(cyc), 180'(11 + 10 * w));
      check("kv_data", k_data, exp_win((w % 16) / N, w % N));
      check("kv_sel", 180'(k_sel), 180'(w / 16));
      kv_n++;
    end
    if (wr_en) begin
      w = wr_n;
      check("wr_cyc", 180'(cyc), 180'(15 + 10 * w));
      check("wr_sel", 180'(wr_sel), 180'(w / 16));
      check("wr_addr", 180'(wr_addr), 180'(w % 16));
      check("wr_data", 180'(wr_data), 180'({1'b0, gold((w % 16) / N, w % N, w / 16)}));
      wr_n++;
    end
    if (done) begin
      check("done_cyc", 180'(cyc), 180'(16 + 10 * (2 * N * N - 1)));
      check("done_busy", 180'(busy), 180'(0));
      check("kv_total", 180'(kv_n), 180'(2 * N * N));
      check("wr_total", 180'(wr_n), 180'(2 * N * N));
    end
  end

  task automatic wait_cyc(input int n);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (cyc != n && k < 2000);
    if (cyc != n) check("wait_timeout", 180'(cyc), 180'(n));
    #1;
  endtask

  task automatic start_run();
    @(negedge clk);
    start = 1'b1; mark = 1'b1;
    @(negedge clk);
    start = 1'b0; mark = 1'b0;
    #1;
  endtask

  initial begin
    int e0[9];
    int e5[9];
    int e15[9];
    int acc;
    e0  = '{0, 0, 0, 0, 0, 1, 0, 4, 5};
    e5  = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    e15 = '{10, 11, 0, 14, 15, 0, 0, 0, 0};
    reset = 1'b1; start = 1'b0; spur = 1'b0; mark = 1'b0;
    rnd_on = 1'b1; rnd_kv = 1'b0; rnd_kd = '0; rnd_md = '0;
    #1 reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      start  = 1'($urandom);
      rnd_kv = 1'($urandom);
      rnd_kd = 19'($urandom);
      rnd_md = 20'($urandom);
      #1;
      check("rst_outs", 180'({busy, done, mem_rd, mem_addr, k_valid, k_sel,
                              wr_en, wr_sel, wr_addr, wr_data}), 180'(0));
      check("rst_kdata", k_data, 180'(0));
    end
    @(negedge clk);
    start = 1'b0; rnd_on = 1'b0; reset = 1'b1;
    repeat (3) @(negedge clk);
    #1 check("idle_after_rst", 180'({busy, mem_rd, k_valid}), 180'(0));

    // Run 1: full image, spurious kernel pulse and a start while busy.
    start_run();
    check("busy_c1", 180'(busy), 180'(1));
    wait_cyc(5);
    spur = 1'b1;
    wait_cyc(6);
    spur = 1'b0;
    check("spur_no_wr", 180'(wr_en), 180'(0));
    wait_cyc(11);
    check("w0_kvalid", 180'(k_valid), 180'(1));
    for (int i = 0; i < 9; i++) check($sformatf("w0_slot%0d", i), 180'(slot(k_data, i)), 180'(e0[i]));
    wait_cyc(15);
    check("wr0", 180'({wr_en, wr_sel, wr_addr}), 180'({1'b1, 1'b0, 4'd0}));
    wait_cyc(50);
    start = 1'b1;
    wait_cyc(51);
    start = 1'b0;
    wait_cyc(61);
    for (int i = 0; i < 9; i++) check($sformatf("w5_slot%0d", i), 180'(slot(k_data, i)), 180'(e5[i]));
    wait_cyc(161);
    for (int i = 0; i < 9; i++) check($sformatf("w15_slot%0d", i), 180'(slot(k_data, i)), 180'(e15[i]));
    wait_cyc(175);
    check("wr16", 180'({wr_en, wr_sel, wr_addr}), 180'({1'b1, 1'b1, 4'd0}));
    wait_cyc(326);
    check("done_pulse", 180'({done, busy}), 180'({1'b1, 1'b0}));

    // Run 2: start right after done, then reset while the first result is in flight.
    start_run();
    check("restart_busy", 180'(busy), 180'(1));
    wait_cyc(6);
    check("restart_fetch", 180'({mem_rd, mem_addr}), 180'({1'b1, 4'd1}));
    wait_cyc(11);
    check("restart_kv", 180'(k_valid), 180'(1));
    wait_cyc(13);
    reset = 1'b0;
    #1 check("midrst_outs", 180'({busy, mem_rd, mem_addr, k_valid, wr_en}), 180'(0));
    wait_cyc(14);
    reset = 1'b1;
    wait_cyc(15);
    check("midrst_no_wr", 180'(wr_en), 180'(0));
    acc = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      #1 if (busy || mem_rd || wr_en || k_valid || done) acc++;
    end
    check("midrst_idle", 180'(acc), 180'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
